wbs_gpio_timer: RTL

Wishbone responder (slave) for the mcu's 32-bit Wishbone master port. It replaces the test loopback register with a real peripheral.
- Eight 32-bit registers: ID, scratch, GPIO out, GPIO in, W1C status, control, timer count, timer compare.
- One level interrupt output `irq`, intended to feed a free `ipending` slot in the mcu.
- Address decode above `adr_i[2:0]` is done outside this block: external logic gates `stb_i`.

---
 rtl/wbs_pkg.sv | 17 +
 rtl/wbs_gpi_sync.sv | 38 +++
 rtl/wbs_gpio_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/wbs_pkg.sv
// Shared register offsets and bit positions for the Wishbone GPIO/timer peripheral.
package wbs_pkg;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_SCRATCH = 3'd1;
    localparam logic [2:0] REG_GPO     = 3'd2;
    localparam logic [2:0] REG_GPI     = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_TCOUNT  = 3'd6;
    localparam logic [2:0] REG_TCMP    = 3'd7;

    localparam int CTRL_RUN = 30;
    localparam int CTRL_TIE = 31;
    localparam int STAT_TMR = 31;

endpackage

// File: rtl/wbs_gpi_sync.sv
// Two-flop synchronizer for the general-purpose inputs plus a rising-edge pulse
// derived from the synchronized value.
module wbs_gpi_sync #(
    parameter int GPI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [GPI_W-1:0] gpi,
    output logic [GPI_W-1:0] sync,
    output logic [GPI_W-1:0] rise
);

    logic [GPI_W-1:0] meta_q, meta_d;
    logic [GPI_W-1:0] sync_q, sync_d;
    logic [GPI_W-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = gpi;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/wbs_gpio_timer.sv
// Wishbone responder with scratch, GPIO, W1C edge status, a compare-match timer
// and a registered level interrupt.
module wbs_gpio_timer
    import wbs_pkg::*;
#(
    parameter int          GPI_W = 8,
    parameter int          GPO_W = 8,
    parameter logic [31:0] ID    = 32'h5742_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [14:0]      adr_i,
    input  logic [31:0]      dat_i,
    input  logic             we_i,
    input  logic             stb_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    input  logic [GPI_W-1:0] gpi,
    output logic [GPO_W-1:0] gpo,
    output logic             irq
);

    localparam logic [31:0] GPI_MASK  = 32'((33'd1 << GPI_W) - 33'd1);
    localparam logic [31:0] STAT_MASK = GPI_MASK | (32'd1 << STAT_TMR);
    localparam logic [31:0] CTRL_MASK = GPI_MASK | (32'd1 << CTRL_RUN) | (32'd1 << CTRL_TIE);

    logic [GPI_W-1:0] gpi_sync, gpi_rise;

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic [GPO_W-1:0] gpo_q, gpo_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      status_q, status_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic [31:0]      tcount_q, tcount_d;
    logic [31:0]      tcmp_q, tcmp_d;
    logic             irq_q, irq_d;

    logic        xfer, wr_en, match, wr_tcount;
    logic [2:0]  reg_sel;
    logic [31:0] rd_data;
    logic        unused_adr;

    wbs_gpi_sync #(.GPI_W(GPI_W)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .gpi  (gpi),
        .sync (gpi_sync),
        .rise (gpi_rise)
    );

    assign reg_sel    = adr_i[2:0];
    assign xfer       = stb_i & ~ack_q;
    assign wr_en      = xfer & we_i;
    assign wr_tcount  = wr_en && (reg_sel == REG_TCOUNT);
    assign match      = ctrl_q[CTRL_RUN] && (tcount_q == tcmp_q);
    assign unused_adr = ^adr_i[14:3];

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_ID:      rd_data = ID;
            REG_SCRATCH: rd_data = scratch_q;
            REG_GPO:     rd_data = 32'(gpo_q);
            REG_GPI:     rd_data = 32'(gpi_sync);
            REG_STATUS:  rd_data = status_q;
            REG_CTRL:    rd_data = ctrl_q;
            REG_TCOUNT:  rd_data = tcount_q;
            REG_TCMP:    rd_data = tcmp_q;
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        ack_d     = stb_i & ~ack_q;
        dat_d     = dat_q;
        gpo_d     = gpo_q;
        scratch_d = scratch_q;
        status_d  = status_q;
        ctrl_d    = ctrl_q;
        tcount_d  = tcount_q;
        tcmp_d    = tcmp_q;

        if (xfer) dat_d = rd_data;

        if (wr_en) begin
            case (reg_sel)
                REG_SCRATCH: scratch_d = dat_i;
                REG_GPO:     gpo_d     = dat_i[GPO_W-1:0];
                REG_STATUS:  status_d  = status_q & ~dat_i;
                REG_CTRL:    ctrl_d    = dat_i & CTRL_MASK;
                REG_TCMP:    tcmp_d    = dat_i;
                default:     ;
            endcase
        end

        // Set events are applied after the W1C so a coincident edge or match wins.
        status_d[GPI_W-1:0] = status_d[GPI_W-1:0] | gpi_rise;

        // A bus write to TCOUNT overrides counting and suppresses the match flag.
        if (wr_tcount) begin
            tcount_d = dat_i;
        end else if (ctrl_q[CTRL_RUN]) begin
            if (match) begin
                tcount_d           = '0;
                status_d[STAT_TMR] = 1'b1;
            end else begin
                tcount_d = tcount_q + 32'd1;
            end
        end

        status_d = status_d & STAT_MASK;

        irq_d = (|(status_q[GPI_W-1:0] & ctrl_q[GPI_W-1:0]))
              | (status_q[STAT_TMR] & ctrl_q[CTRL_TIE]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            gpo_q     <= '0;
            scratch_q <= '0;
            status_q  <= '0;
            ctrl_q    <= '0;
            tcount_q  <= '0;
            tcmp_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            gpo_q     <= gpo_d;
            scratch_q <= scratch_d;
            status_q  <= status_d;
            ctrl_q    <= ctrl_d;
            tcount_q  <= tcount_d;
            tcmp_q    <= tcmp_d;
            irq_q     <= irq_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign gpo   = gpo_q;
    assign irq   = irq_q;

endmodule
